fwd_scoreboard_unit: RTL and testbench

//  Parametrised operand-forwarding and hazard control for the RV32IMC pipeline.

---
 rtl/fwd_scoreboard_unit_pkg.sv | 8 +
 rtl/fwd_scoreboard_unit_if.sv | 36 +++
 rtl/fwd_scoreboard_unit_match.sv | 39 +++
 rtl/fwd_scoreboard_unit.sv | 60 ++++++
 tb/tb_fwd_scoreboard_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fwd_scoreboard_unit_pkg.sv
// fwd_scoreboard_unit_pkg: shared register/select constants for the forwarding unit
package fwd_scoreboard_unit_pkg;
  localparam logic [4:0] REG_X0 = 5'd0;
  localparam int SEL_RF = 0;
  function automatic int fw_sel_stage(input int k);
    return k + 1;
  endfunction
endpackage

// File: rtl/fwd_scoreboard_unit_if.sv
// fwd_scoreboard_unit_if: ID/stage/long-unit signals seen by the forwarding unit
interface fwd_scoreboard_unit_if #(
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 3,
  parameter int CNTW = 16
);
  localparam int SELW = $clog2(NUM_STG + 2);
  logic id_valid;
  logic [5*NUM_SRC-1:0] id_rs;
  logic [NUM_SRC-1:0] id_rs_used;
  logic [4:0] id_rd;
  logic id_wr_en;
  logic id_long;
  logic flush;
  logic [5*NUM_STG-1:0] stg_rd;
  logic [NUM_STG-1:0] stg_wr_en;
  logic [NUM_STG-1:0] stg_rdy;
  logic lu_done;
  logic [4:0] lu_rd;
  logic [SELW*NUM_SRC-1:0] fw_sel;
  logic stall;
  logic id_ready;
  logic lu_busy;
  logic [CNTW-1:0] stall_cnt;
  logic sb_err;
  modport slave (
    input id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_long, flush,
    input stg_rd, stg_wr_en, stg_rdy, lu_done, lu_rd,
    output fw_sel, stall, id_ready, lu_busy, stall_cnt, sb_err
  );
  modport master (
    output id_valid, id_rs, id_rs_used, id_rd, id_wr_en, id_long, flush,
    output stg_rd, stg_wr_en, stg_rdy, lu_done, lu_rd,
    input fw_sel, stall, id_ready, lu_busy, stall_cnt, sb_err
  );
endinterface

// File: rtl/fwd_scoreboard_unit_match.sv
// fwd_scoreboard_unit_match: per-operand stage priority encode to bypass select and hazard flag
module fwd_scoreboard_unit_match
  import fwd_scoreboard_unit_pkg::*;
#(
  parameter int NUM_STG = 3,
  parameter int SELW = 3
) (
  input  logic [4:0] rs,
  input  logic rs_used,
  input  logic rs_pending,
  input  logic [5*NUM_STG-1:0] stg_rd,
  input  logic [NUM_STG-1:0] stg_wr_en,
  input  logic [NUM_STG-1:0] stg_rdy,
  input  logic lu_done,
  input  logic [4:0] lu_rd,
  output logic [SELW-1:0] sel,
  output logic hold
);
  logic active, lu_hit, stg_hit, stg_hold;
  logic [SELW-1:0] stg_sel;
  assign active = rs_used && rs != REG_X0;
  assign lu_hit = lu_done && lu_rd == rs;
  // oldest-to-youngest sweep so the youngest matching stage is the last writer
  always_comb begin
    stg_hit = 1'b0;
    stg_hold = 1'b0;
    stg_sel = SELW'(SEL_RF);
    for (int k = NUM_STG - 1; k >= 0; k--)
      if (stg_wr_en[k] && stg_rd[5*k+:5] == rs) begin
        stg_hit = 1'b1;
        stg_hold = !stg_rdy[k];
        stg_sel = stg_rdy[k] ? SELW'(fw_sel_stage(k)) : SELW'(SEL_RF);
      end
  end
  assign sel = !active ? SELW'(SEL_RF) :
               stg_hit ? stg_sel :
               (rs_pending && lu_hit) ? SELW'(NUM_STG + 1) : SELW'(SEL_RF);
  assign hold = active && (stg_hit ? stg_hold : rs_pending && !lu_hit);
endmodule

// File: rtl/fwd_scoreboard_unit.sv
// fwd_scoreboard_unit: operand bypass selects, ID stall and long-latency scoreboard
module fwd_scoreboard_unit
  import fwd_scoreboard_unit_pkg::*;
#(
  parameter int NUM_SRC = 2,
  parameter int NUM_STG = 3,
  parameter int MAX_LONG = 2,
  parameter int CNTW = 16
) (
  input logic clk,
  input logic rst,
  fwd_scoreboard_unit_if.slave bus
);
  localparam int SELW = $clog2(NUM_STG + 2);
  localparam int OW = $clog2(MAX_LONG + 1);
  logic [31:0] pending, clr_mask, set_mask;
  logic [OW-1:0] outstanding;
  logic [SELW*NUM_SRC-1:0] sel;
  logic [NUM_SRC-1:0] hold;
  logic lu_id_hit, hazard, stall_c, long_issue, done_ok;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    fwd_scoreboard_unit_match #(.NUM_STG(NUM_STG), .SELW(SELW)) u_match (
      .rs(bus.id_rs[5*i+:5]),
      .rs_used(bus.id_rs_used[i]),
      .rs_pending(pending[bus.id_rs[5*i+:5]]),
      .stg_rd(bus.stg_rd),
      .stg_wr_en(bus.stg_wr_en),
      .stg_rdy(bus.stg_rdy),
      .lu_done(bus.lu_done),
      .lu_rd(bus.lu_rd),
      .sel(sel[SELW*i+:SELW]),
      .hold(hold[i])
    );
  end
  assign lu_id_hit = bus.lu_done && bus.lu_rd == bus.id_rd;
  assign hazard = (|hold) || (bus.id_long && outstanding == OW'(MAX_LONG)) ||
                  (bus.id_wr_en && pending[bus.id_rd] && !lu_id_hit);
  assign stall_c = bus.id_valid && !bus.flush && hazard;
  assign long_issue = bus.id_valid && !bus.flush && !stall_c && bus.id_long;
  assign done_ok = bus.lu_done && pending[bus.lu_rd];
  assign clr_mask = bus.lu_done ? 32'd1 << bus.lu_rd : '0;
  assign set_mask = (long_issue && bus.id_wr_en && bus.id_rd != REG_X0) ? 32'd1 << bus.id_rd : '0;
  assign bus.stall = rst || stall_c;
  assign bus.id_ready = !bus.stall;
  assign bus.fw_sel = rst ? '0 : sel;
  assign bus.lu_busy = outstanding != '0;
  // set after clear: a register can retire and be re-issued in the same cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending <= '0;
      outstanding <= '0;
      bus.stall_cnt <= '0;
      bus.sb_err <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | set_mask;
      outstanding <= outstanding + OW'(long_issue) - OW'(done_ok);
      if (bus.lu_done && !pending[bus.lu_rd]) bus.sb_err <= 1'b1;
      if (stall_c && !(&bus.stall_cnt)) bus.stall_cnt <= bus.stall_cnt + CNTW'(1);
    end
endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// tb_fwd_scoreboard_unit: vector table, directed hazard sequences and random run against a reference model
module tb_fwd_scoreboard_unit;
  localparam int NUM_SRC = 2, NUM_STG = 3, MAX_LONG = 2, CNTW = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fwd_scoreboard_unit_if #(.NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .CNTW(CNTW)) bus ();
  fwd_scoreboard_unit #(.NUM_SRC(NUM_SRC), .NUM_STG(NUM_STG), .MAX_LONG(MAX_LONG), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .bus(bus));
  int n_pass = 0, n_tot = 0;
  bit m_pend [32];
  int m_out, m_cnt;
  bit m_err;
  typedef struct {
    bit vld; logic [9:0] rs; logic [1:0] used; logic [14:0] srd;
    logic [2:0] swe, srdy; int s0, s1; bit st;
  } vec_t;
  vec_t vt [12];
  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  function automatic vec_t mk(input bit vld, input int r1, input int r0, input logic [1:0] used,
                              input int d2, input int d1, input int d0, input logic [2:0] swe,
                              input logic [2:0] srdy, input int s0, input int s1, input bit st);
    vec_t v;
    v.vld = vld; v.rs = {5'(r1), 5'(r0)}; v.used = used;
    v.srd = {5'(d2), 5'(d1), 5'(d0)}; v.swe = swe; v.srdy = srdy;
    v.s0 = s0; v.s1 = s1; v.st = st;
    return v;
  endfunction
  function automatic void m_reset();
    foreach (m_pend[r]) m_pend[r] = 1'b0;
    m_out = 0; m_cnt = 0; m_err = 1'b0;
  endfunction
  // reference: youngest writing stage decides, else the long-op scoreboard
  function automatic void m_op(input int i, output int sel, output bit hold);
    int rs;
    rs = int'(bus.id_rs[5*i+:5]);
    sel = 0; hold = 1'b0;
    if (!bus.id_rs_used[i] || rs == 0) return;
    for (int k = 0; k < NUM_STG; k++)
      if (bus.stg_wr_en[k] && int'(bus.stg_rd[5*k+:5]) == rs) begin
        if (bus.stg_rdy[k]) sel = k + 1; else hold = 1'b1;
        return;
      end
    if (m_pend[rs]) begin
      if (bus.lu_done && int'(bus.lu_rd) == rs) sel = NUM_STG + 1; else hold = 1'b1;
    end
  endfunction
  function automatic bit m_stall();
    int s;
    bit h0, h1, full, waw;
    m_op(0, s, h0);
    m_op(1, s, h1);
    full = bus.id_long && m_out == MAX_LONG;
    waw = bus.id_wr_en && m_pend[bus.id_rd] && !(bus.lu_done && bus.lu_rd == bus.id_rd);
    return bus.id_valid && !bus.flush && (h0 || h1 || full || waw);
  endfunction
  task automatic check_all(input string nm);
    int s0, s1;
    bit h, st;
    m_op(0, s0, h);
    m_op(1, s1, h);
    st = m_stall();
    chk({nm, ".stall"}, int'(bus.stall), int'(st));
    chk({nm, ".ready"}, int'(bus.id_ready), int'(!st));
    chk({nm, ".sel0"}, int'(bus.fw_sel[2:0]), s0);
    chk({nm, ".sel1"}, int'(bus.fw_sel[5:3]), s1);
    chk({nm, ".busy"}, int'(bus.lu_busy), int'(m_out != 0));
    chk({nm, ".cnt"}, int'(bus.stall_cnt), m_cnt);
    chk({nm, ".err"}, int'(bus.sb_err), int'(m_err));
  endtask
  task automatic m_edge();
    bit st, ok;
    st = m_stall();
    ok = bus.lu_done && m_pend[bus.lu_rd];
    if (bus.lu_done && !ok) m_err = 1'b1;
    if (bus.lu_done) m_pend[bus.lu_rd] = 1'b0;
    if (bus.id_valid && !bus.flush && !st && bus.id_long) begin
      m_out++;
      if (bus.id_wr_en && bus.id_rd != 5'd0) m_pend[bus.id_rd] = 1'b1;
    end
    if (ok) m_out--;
    if (st && m_cnt < (1 << CNTW) - 1) m_cnt++;
  endtask
  task automatic step(input string nm);
    #3;
    check_all(nm);
  endtask
  task automatic adv();
    m_edge();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.id_valid = 1'b0; bus.id_rs = '0; bus.id_rs_used = '0; bus.id_rd = '0;
    bus.id_wr_en = 1'b0; bus.id_long = 1'b0; bus.flush = 1'b0;
    bus.stg_rd = '0; bus.stg_wr_en = '0; bus.stg_rdy = '0;
    bus.lu_done = 1'b0; bus.lu_rd = '0;
  endtask
  task automatic set_id(input bit vld, input int rs0, input int rs1, input logic [1:0] used,
                        input int rd, input bit wr, input bit lng);
    bus.id_valid = vld; bus.id_rs = {5'(rs1), 5'(rs0)}; bus.id_rs_used = used;
    bus.id_rd = 5'(rd); bus.id_wr_en = wr; bus.id_long = lng;
  endtask
  task automatic set_stg(input int k, input int rd, input bit we, input bit rdy);
    bus.stg_rd[5*k+:5] = 5'(rd); bus.stg_wr_en[k] = we; bus.stg_rdy[k] = rdy;
  endtask
  task automatic do_reset();
    idle();
    rst = 1'b1;
    #1;
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    int q[$];
    vt[0]  = mk(1, 0, 5, 2'b01, 0, 0, 5, 3'b001, 3'b001, 1, 0, 0);
    vt[1]  = mk(1, 0, 5, 2'b01, 5, 0, 5, 3'b101, 3'b101, 1, 0, 0);
    vt[2]  = mk(1, 0, 5, 2'b01, 5, 5, 0, 3'b110, 3'b110, 2, 0, 0);
    vt[3]  = mk(1, 0, 5, 2'b01, 5, 0, 0, 3'b100, 3'b100, 3, 0, 0);
    vt[4]  = mk(1, 0, 5, 2'b01, 0, 5, 5, 3'b011, 3'b010, 0, 0, 1);
    vt[5]  = mk(1, 0, 0, 2'b01, 0, 0, 0, 3'b001, 3'b001, 0, 0, 0);
    vt[6]  = mk(1, 0, 5, 2'b00, 0, 0, 5, 3'b001, 3'b000, 0, 0, 0);
    vt[7]  = mk(1, 0, 5, 2'b01, 0, 0, 5, 3'b000, 3'b000, 0, 0, 0);
    vt[8]  = mk(1, 6, 5, 2'b11, 0, 6, 5, 3'b011, 3'b011, 1, 2, 0);
    vt[9]  = mk(1, 6, 5, 2'b11, 6, 0, 5, 3'b101, 3'b001, 1, 0, 1);
    vt[10] = mk(0, 0, 5, 2'b01, 0, 5, 5, 3'b011, 3'b010, 0, 0, 0);
    vt[11] = mk(1, 5, 5, 2'b11, 0, 0, 5, 3'b001, 3'b001, 1, 1, 0);
    idle();
    set_stg(0, 5, 1, 1);
    set_id(1, 5, 0, 2'b01, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("rst.stall", int'(bus.stall), 1);
    chk("rst.ready", int'(bus.id_ready), 0);
    chk("rst.sel", int'(bus.fw_sel), 0);
    chk("rst.busy", int'(bus.lu_busy), 0);
    chk("rst.cnt", int'(bus.stall_cnt), 0);
    chk("rst.err", int'(bus.sb_err), 0);
    m_reset();
    rst = 1'b0;
    foreach (vt[j]) begin
      idle();
      bus.id_valid = vt[j].vld; bus.id_rs = vt[j].rs; bus.id_rs_used = vt[j].used;
      bus.stg_rd = vt[j].srd; bus.stg_wr_en = vt[j].swe; bus.stg_rdy = vt[j].srdy;
      step($sformatf("vec%0d", j));
      chk($sformatf("vec%0d.st", j), int'(bus.stall), int'(vt[j].st));
      chk($sformatf("vec%0d.s0", j), int'(bus.fw_sel[2:0]), vt[j].s0);
      chk($sformatf("vec%0d.s1", j), int'(bus.fw_sel[5:3]), vt[j].s1);
      adv();
    end
    do_reset();
    set_stg(0, 5, 1, 1); set_id(1, 5, 0, 2'b01, 0, 0, 0);
    step("t1");
    chk("t1.sel0", int'(bus.fw_sel[2:0]), 1); chk("t1.stall", int'(bus.stall), 0);
    adv();
    idle(); set_stg(0, 6, 1, 0); set_id(1, 0, 6, 2'b10, 0, 0, 0);
    step("t2a");
    chk("t2.lu_stall", int'(bus.stall), 1);
    adv();
    idle(); set_stg(1, 6, 1, 1); set_id(1, 0, 6, 2'b10, 0, 0, 0);
    step("t2b");
    chk("t2.sel1", int'(bus.fw_sel[5:3]), 2); chk("t2.stall", int'(bus.stall), 0);
    chk("t2.cnt", int'(bus.stall_cnt), 1);
    adv();
    idle(); set_id(1, 0, 0, 2'b00, 7, 1, 1);
    step("t3i");
    chk("t3.issue", int'(bus.stall), 0);
    adv();
    idle(); set_id(1, 7, 0, 2'b01, 0, 0, 0);
    for (int c = 0; c < 5; c++) begin
      step("t3w");
      chk("t3.raw", int'(bus.stall), 1); chk("t3.busy", int'(bus.lu_busy), 1);
      adv();
    end
    bus.lu_done = 1'b1; bus.lu_rd = 5'd7;
    step("t3d");
    chk("t3.sel_lu", int'(bus.fw_sel[2:0]), 4); chk("t3.stall_d", int'(bus.stall), 0);
    adv();
    bus.lu_done = 1'b0;
    step("t3c");
    chk("t3.clear", int'(bus.stall), 0); chk("t3.idle", int'(bus.lu_busy), 0);
    adv();
    idle(); set_id(1, 0, 0, 2'b00, 8, 1, 1); step("t4a"); adv();
    set_id(1, 0, 0, 2'b00, 9, 1, 1); step("t4b"); adv();
    set_id(1, 0, 0, 2'b00, 11, 1, 1);
    step("t4c");
    chk("t4.full", int'(bus.stall), 1);
    adv();
    bus.lu_done = 1'b1; bus.lu_rd = 5'd8;
    step("t4d");
    chk("t4.full_done", int'(bus.stall), 1);
    adv();
    bus.lu_done = 1'b0;
    step("t4e");
    chk("t4.issue", int'(bus.stall), 0);
    adv();
    set_id(1, 0, 0, 2'b00, 12, 1, 1);
    step("t4f");
    chk("t4.refull", int'(bus.stall), 1);
    adv();
    idle(); bus.lu_done = 1'b1; bus.lu_rd = 5'd9; step("t4g"); adv();
    bus.lu_rd = 5'd11; step("t4h"); adv();
    bus.lu_done = 1'b0;
    step("t4i");
    chk("t4.drained", int'(bus.lu_busy), 0);
    adv();
    set_id(1, 0, 0, 2'b00, 10, 1, 1); step("t5i"); adv();
    set_id(1, 0, 0, 2'b00, 10, 1, 0);
    for (int c = 0; c < 2; c++) begin
      step("t5w");
      chk("t5.waw", int'(bus.stall), 1);
      adv();
    end
    bus.flush = 1'b1;
    step("t5f");
    chk("t5.flush", int'(bus.stall), 0);
    adv();
    bus.flush = 1'b0; bus.lu_done = 1'b1; bus.lu_rd = 5'd10;
    step("t5d");
    chk("t5.done", int'(bus.stall), 0);
    adv();
    idle(); step("t5e"); adv();
    for (int c = 0; c < 600; c++) begin
      bus.id_valid = $urandom_range(0, 7) != 0;
      bus.id_rs = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      bus.id_rs_used = 2'($urandom);
      bus.id_long = $urandom_range(0, 3) == 0;
      bus.id_wr_en = bus.id_long || ($urandom_range(0, 1) != 0);
      bus.id_rd = bus.id_long ? 5'($urandom_range(1, 7)) : 5'($urandom_range(0, 7));
      bus.flush = $urandom_range(0, 9) == 0;
      for (int k = 0; k < NUM_STG; k++)
        set_stg(k, int'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0);
      q.delete();
      for (int r = 1; r < 32; r++) if (m_pend[r]) q.push_back(r);
      bus.lu_done = q.size() != 0 && $urandom_range(0, 2) == 0;
      bus.lu_rd = bus.lu_done ? 5'(q[$urandom_range(0, q.size() - 1)]) : 5'($urandom_range(0, 31));
      step("rnd");
      adv();
    end
    do_reset();
    set_id(1, 0, 0, 2'b00, 12, 1, 1); step("t6i"); adv();
    idle(); bus.lu_done = 1'b1; bus.lu_rd = 5'd3; step("t6d"); adv();
    bus.lu_done = 1'b0;
    step("t6e");
    chk("t6.err", int'(bus.sb_err), 1); chk("t6.busy", int'(bus.lu_busy), 1);
    adv();
    set_id(1, 12, 0, 2'b01, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("t6.arst_busy", int'(bus.lu_busy), 0);
    chk("t6.arst_err", int'(bus.sb_err), 0);
    chk("t6.arst_cnt", int'(bus.stall_cnt), 0);
    chk("t6.arst_stall", int'(bus.stall), 1);
    chk("t6.arst_sel", int'(bus.fw_sel), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t6r");
    chk("t6.unpend", int'(bus.stall), 0);
    adv();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
